// File: rtl/ddr3_pattern_tester.sv
// Post-calibration DDR3 self-test: writes an LFSR pattern, reads it back, flags byte lanes.
// Optional second inverted-data pass under MEMTEST_INVERT_PASS_EN.
module ddr3_pattern_tester #(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned TEST_WORDS = 1024,
    parameter logic [15:0] SEED       = 16'hA5C3,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              sys_resetn,
    input  logic              write_level_done,
    input  logic              read_calib_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              test_done,
    output logic              fail_high,
    output logic              fail_low
);

    localparam int unsigned CW = ADDR_W + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TEST_WORDS - 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RWAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          fail_hi_q, fail_hi_d;
    logic          fail_lo_q, fail_lo_d;
    logic          done_q, done_d;
`ifdef MEMTEST_INVERT_PASS_EN
    logic          pass_q, pass_d;
`endif

    logic          init_ok;
    logic          req;
    logic          stall;
    logic          wd_expire;
    logic          last_word;
    logic [15:0]   lfsr_next;
    logic [15:0]   pat;

    assign init_ok   = write_level_done & read_calib_done;
    assign req       = (state_q == S_WRITE) || (state_q == S_READ);
    assign last_word = (cnt_q == LAST);
    assign lfsr_next = {lfsr_q[14:0],
                        lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall     = (req && !mem_ack) ||
                       ((state_q == S_RWAIT) && !mem_rvalid);
    assign wd_expire = stall && (wdog_q == WD_LAST);

`ifdef MEMTEST_INVERT_PASS_EN
    assign pat = pass_q ? ~lfsr_q : lfsr_q;
`else
    assign pat = lfsr_q;
`endif

    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lfsr_q    <= SEED;
            wdog_q    <= '0;
            fail_hi_q <= 1'b0;
            fail_lo_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef MEMTEST_INVERT_PASS_EN
            pass_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            wdog_q    <= wdog_d;
            fail_hi_q <= fail_hi_d;
            fail_lo_q <= fail_lo_d;
            done_q    <= done_d;
`ifdef MEMTEST_INVERT_PASS_EN
            pass_q    <= pass_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        wdog_d    = '0;
        fail_hi_d = fail_hi_q;
        fail_lo_d = fail_lo_q;
        done_d    = done_q;
`ifdef MEMTEST_INVERT_PASS_EN
        pass_d    = pass_q;
`endif
        if (!init_ok) begin
            // controller went back into reset: abandon and wait for retest
            state_d   = S_IDLE;
            cnt_d     = '0;
            lfsr_d    = SEED;
            fail_hi_d = 1'b0;
            fail_lo_d = 1'b0;
            done_d    = 1'b0;
`ifdef MEMTEST_INVERT_PASS_EN
            pass_d    = 1'b0;
`endif
        end else begin
            if (stall) begin
                wdog_d = wdog_q + 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    state_d   = S_WRITE;
                    cnt_d     = '0;
                    lfsr_d    = SEED;
                    fail_hi_d = 1'b0;
                    fail_lo_d = 1'b0;
                    done_d    = 1'b0;
`ifdef MEMTEST_INVERT_PASS_EN
                    pass_d    = 1'b0;
`endif
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        cnt_d  = cnt_q + 1'b1;
                        lfsr_d = lfsr_next;
                        if (last_word) begin
                            cnt_d   = '0;
                            lfsr_d  = SEED;
                            state_d = S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (mem_ack) begin
                        state_d = S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (mem_rvalid) begin
                        fail_hi_d = fail_hi_q | (mem_rdata[15:8] != pat[15:8]);
                        fail_lo_d = fail_lo_q | (mem_rdata[7:0] != pat[7:0]);
                        cnt_d     = cnt_q + 1'b1;
                        lfsr_d    = lfsr_next;
                        state_d   = S_READ;
                        if (last_word) begin
`ifdef MEMTEST_INVERT_PASS_EN
                            if (!pass_q) begin
                                pass_d  = 1'b1;
                                cnt_d   = '0;
                                lfsr_d  = SEED;
                                state_d = S_WRITE;
                            end else begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
`else
                            state_d = S_DONE;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            if (wd_expire) begin
                fail_hi_d = 1'b1;
                fail_lo_d = 1'b1;
                done_d    = 1'b1;
                wdog_d    = '0;
                state_d   = S_DONE;
            end
        end
    end

    always_comb begin
        mem_req   = req;
        mem_we    = (state_q == S_WRITE);
        mem_addr  = req ? cnt_q[ADDR_W-1:0] : '0;
        mem_wdata = (state_q == S_WRITE) ? pat : 16'h0000;
        busy      = req || (state_q == S_RWAIT);
        test_done = done_q;
        fail_high = fail_hi_q;
        fail_low  = fail_lo_q;
    end

endmodule

// File: tb/tb_ddr3_pattern_tester.sv
// Scoreboard bench for ddr3_pattern_tester with a small RAM model.
// Build with MEMTEST_INVERT_PASS_EN to also expect the inverted second pass.
module tb_ddr3_pattern_tester;

    localparam int AW = 22;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    localparam logic [15:0] PAT [4] = '{16'hA5C3, 16'h4B87, 16'h970E, 16'h2E1D};

    logic          clk = 1'b0;
    logic          sys_resetn;
    logic          write_level_done;
    logic          read_calib_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_ack = 1'b0;
    logic [15:0]   mem_rdata = 16'h0000;
    logic          mem_rvalid = 1'b0;
    logic          busy;
    logic          test_done;
    logic          fail_high;
    logic          fail_low;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_mis = 0;
    bit          sb_on = 1'b1;
    bit          ack_en = 1'b1;
    bit          ack_wait = 1'b0;
    bit          done_prev = 1'b0;
    int          rd_delay = 0;
    logic [15:0] ram [8];
    logic [15:0] corrupt [4];

    always #5 clk = ~clk;

    ddr3_pattern_tester #(
        .ADDR_W    (AW),
        .TEST_WORDS(4),
        .SEED      (16'hA5C3),
        .TIMEOUT   (16)
    ) dut (
        .clk             (clk),
        .sys_resetn      (sys_resetn),
        .write_level_done(write_level_done),
        .read_calib_done (read_calib_done),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .mem_rvalid      (mem_rvalid),
        .busy            (busy),
        .test_done       (test_done),
        .fail_high       (fail_high),
        .fail_low        (fail_low)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic observe(input int kind, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        if (!sb_on) return;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_event: kind %0d addr %h data %h", kind, addr, data);
            return;
        end
        e = exp_q.pop_front();
        chk("sb_kind", 32'(kind), 32'(e.kind));
        chk("sb_addr", addr, e.addr);
        chk("sb_data", data, e.data);
    endtask

    // RAM model: ack one cycle after request, read data two cycles after ack
    always @(negedge clk) begin
        logic hs;
        logic [2:0] a;
        hs = 1'b0;
        a  = mem_addr[2:0];
        if (rd_delay > 0) begin
            rd_delay--;
            mem_rvalid = (rd_delay == 0);
        end else begin
            mem_rvalid = 1'b0;
        end
        if (mem_req && ack_en && sys_resetn && write_level_done && read_calib_done) begin
            if (ack_wait) begin
                mem_ack  = 1'b1;
                ack_wait = 1'b0;
                hs       = 1'b1;
            end else begin
                mem_ack  = 1'b0;
                ack_wait = 1'b1;
            end
        end else begin
            mem_ack  = 1'b0;
            ack_wait = 1'b0;
        end
        if (hs) begin
            if (mem_we) begin
                ram[a] = mem_wdata;
                observe(0, 32'(mem_addr), 32'(mem_wdata));
            end else begin
                rd_delay  = 2;
                mem_rdata = ram[a] ^ corrupt[a[1:0]];
                observe(1, 32'(mem_addr), 32'h0);
            end
        end
        if (test_done && !done_prev) begin
            observe(2, 32'h0, {30'h0, fail_high, fail_low});
        end
        done_prev = test_done;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int addr, input logic [15:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = 32'(addr);
        e.data = 32'(data);
        exp_q.push_back(e);
    endtask

    task automatic push_full(input logic [1:0] verdict);
        int npass;
        logic [15:0] w;
`ifdef MEMTEST_INVERT_PASS_EN
        npass = 2;
`else
        npass = 1;
`endif
        for (int p = 0; p < npass; p++) begin
            for (int i = 0; i < 4; i++) begin
                w = PAT[i];
                if (p == 1) w = ~w;
                push(0, i, w);
            end
            for (int i = 0; i < 4; i++) push(1, i, 16'h0);
        end
        push(2, 0, {14'h0, verdict});
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!test_done && n < 400) begin
            cyc(1);
            n++;
        end
        chk(name, 32'(test_done), 32'h1);
        cyc(2);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic restart_off();
        write_level_done = 1'b0;
        cyc(2);
        chk("off_done", 32'(test_done), 32'h0);
        chk("off_flags", {30'h0, fail_high, fail_low}, 32'h0);
    endtask

    initial begin
        int n;
        sys_resetn       = 1'b0;
        write_level_done = 1'b0;
        read_calib_done  = 1'b0;
        for (int i = 0; i < 8; i++) ram[i] = 16'h0;
        for (int i = 0; i < 4; i++) corrupt[i] = 16'h0;
        cyc(3);
        chk("rst_req_busy", {30'h0, mem_req, busy}, 32'h0);
        chk("rst_done_flags", {29'h0, test_done, fail_high, fail_low}, 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        sys_resetn = 1'b1;
        cyc(2);
        chk("idle_no_init", {30'h0, mem_req, busy}, 32'h0);

        // clean run
        push_full(2'b00);
        write_level_done = 1'b1;
        read_calib_done  = 1'b1;
        cyc(1);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_first_wdata", 32'(mem_wdata), 32'h0000A5C3);
        wait_done("t1_done");

        // upper lane corruption
        restart_off();
        corrupt[2] = 16'h0100;
        push_full(2'b10);
        write_level_done = 1'b1;
        wait_done("t2_done");

        // both lanes corrupted on different words
        restart_off();
        corrupt[2] = 16'h0000;
        corrupt[1] = 16'h0001;
        corrupt[3] = 16'h8000;
        push_full(2'b11);
        write_level_done = 1'b1;
        wait_done("t3_done");

        // no ack ever: watchdog
        restart_off();
        corrupt[1] = 16'h0000;
        corrupt[3] = 16'h0000;
        ack_en = 1'b0;
        push(2, 0, 16'h0003);
        write_level_done = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (test_done) break;
            if (mem_req) n++;
        end
        chk("t4_req_cycles", 32'(n), 32'd16);
        chk("t4_done", 32'(test_done), 32'h1);
        cyc(2);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'h0);
        ack_en = 1'b1;

        // calibration lost during read of addr 1
        restart_off();
        for (int i = 0; i < 4; i++) push(0, i, PAT[i]);
        push(1, 0, 16'h0);
        write_level_done = 1'b1;
        n = 0;
        while (!(mem_req && !mem_we && mem_addr == 1) && n < 200) begin
            cyc(1);
            n++;
        end
        chk("t5_reached_read1", 32'(n < 200), 32'h1);
        read_calib_done = 1'b0;
        cyc(1);
        chk("t5_req_busy", {30'h0, mem_req, busy}, 32'h0);
        chk("t5_flags", {29'h0, test_done, fail_high, fail_low}, 32'h0);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'h0);
        push_full(2'b00);
        read_calib_done = 1'b1;
        wait_done("t5_retest_done");

        // asynchronous reset mid-write
        restart_off();
        sb_on = 1'b0;
        write_level_done = 1'b1;
        n = 0;
        while (!(mem_req && mem_we && mem_addr == 2) && n < 200) begin
            cyc(1);
            n++;
        end
        chk("t6_reached_write2", 32'(n < 200), 32'h1);
        #2;
        sys_resetn = 1'b0;
        #1;
        chk("t6_req_we_busy", {29'h0, mem_req, mem_we, busy}, 32'h0);
        chk("t6_addr_wdata", {mem_wdata, mem_addr[15:0]}, 32'h0);
        chk("t6_done_flags", {29'h0, test_done, fail_high, fail_low}, 32'h0);
        cyc(2);
        sys_resetn = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
